// File: rtl/systolic_pkg.sv
// Shared state encoding and default geometry for the systolic array feeder.
// No logic; imported by the feeder and its skew lines.
package systolic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_FILL,
      ST_W_BURST,
      ST_STREAM,
      ST_DRAIN
   } feeder_state_t;

   localparam int DEF_DATA_SIZE = 32;
   localparam int DEF_N         = 4;
   localparam int DEF_SKEW      = 4;

endpackage

// File: rtl/feeder_skew_line.sv
// Per-row delay line: DEPTH+1 cycles from d_i to q_o (DEPTH=0 is a single register).
// Free-running, no backpressure; zeros are shifted in whenever the feeder has no operand.
module feeder_skew_line
   import systolic_pkg::*;
#(
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int DEPTH     = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_SIZE-1:0] d_i,
   output logic [DATA_SIZE-1:0] q_o
);

   logic [DATA_SIZE-1:0] stage_q [DEPTH+1];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i <= DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i <= DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH];

endmodule

// File: rtl/systolic_feeder.sv
// Loads weight rows into an NxN systolic array and streams skewed activations into its rows.
// Row r output lags acceptance by 1+r*SKEW cycles; in_ready drops during weight bursts and drain.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_SIZE   = DEF_DATA_SIZE,
   parameter int N           = DEF_N,
   parameter int SKEW        = DEF_SKEW,
   parameter int DRAIN_EXTRA = N * SKEW
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N*DATA_SIZE-1:0] in_data,
   input  logic                   in_weight,
   input  logic                   in_last,
   output logic [N*DATA_SIZE-1:0] row_data,
   output logic [N*DATA_SIZE-1:0] col_sum,
   output logic                   ld_weight,
   output logic                   enable,
   output logic                   busy,
   output logic                   err
);

   localparam int W         = N * DATA_SIZE;
   localparam int DRAIN_LEN = (N - 1) * SKEW + DRAIN_EXTRA;
   localparam int CNT_MAX   = (DRAIN_LEN > N) ? DRAIN_LEN : N;
   localparam int CNT_W     = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_LEN - 1);

   feeder_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     wbuf_q [N];
   logic [W-1:0]     wbuf_d [N];
   logic [W-1:0]     col_sum_q, col_sum_d, skew_in;
   logic             ld_weight_q, enable_q, busy_q, err_q;
   logic             accept, act_vld, proto_err;

   assign in_ready = !reset &&
                     (state_q == ST_IDLE || state_q == ST_W_FILL || state_q == ST_STREAM);
   assign accept   = in_valid && in_ready;

   // cnt_q is the fill index in W_FILL, the burst row in W_BURST and the flush count in DRAIN
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      act_vld   = 1'b0;
      proto_err = 1'b0;
      for (int k = 0; k < N; k++) begin
         wbuf_d[k] = wbuf_q[k];
      end
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d = '0;
               if (in_weight) begin
                  wbuf_d[0] = in_data;
                  if (N == 1) begin
                     state_d = ST_W_BURST;
                  end else begin
                     state_d = ST_W_FILL;
                     cnt_d   = CNT_W'(1);
                  end
               end else begin
                  act_vld = 1'b1;
                  state_d = in_last ? ST_DRAIN : ST_STREAM;
               end
            end
         end
         ST_W_FILL: begin
            if (accept) begin
               proto_err = !in_weight;
               for (int k = 0; k < N; k++) begin
                  if (cnt_q == CNT_W'(k)) wbuf_d[k] = in_data;
               end
               if (cnt_q == LAST_ROW) begin
                  state_d = ST_W_BURST;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_W_BURST: begin
            if (cnt_q == LAST_ROW) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STREAM: begin
            if (accept) begin
               proto_err = in_weight;
               act_vld   = 1'b1;
               if (in_last) begin
                  state_d = ST_DRAIN;
                  cnt_d   = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (cnt_q == LAST_DRAIN) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Bottom weight row goes first so that after N shifts PE row r holds wbuf[r]
   always_comb begin
      col_sum_d = '0;
      if (state_d == ST_W_BURST) begin
         for (int k = 0; k < N; k++) begin
            if (cnt_d == CNT_W'(N - 1 - k)) col_sum_d = wbuf_d[k];
         end
      end
   end

   assign skew_in = act_vld ? in_data : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         col_sum_q   <= '0;
         ld_weight_q <= 1'b0;
         enable_q    <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         for (int k = 0; k < N; k++) begin
            wbuf_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         col_sum_q   <= col_sum_d;
         ld_weight_q <= (state_d == ST_W_BURST);
         enable_q    <= (state_d == ST_W_BURST) || (state_d == ST_STREAM) ||
                        (state_d == ST_DRAIN);
         busy_q      <= (state_d != ST_IDLE);
         err_q       <= err_q | proto_err;
         for (int k = 0; k < N; k++) begin
            wbuf_q[k] <= wbuf_d[k];
         end
      end
   end

   for (genvar r = 0; r < N; r++) begin : g_row
      feeder_skew_line #(
         .DATA_SIZE(DATA_SIZE),
         .DEPTH    (r * SKEW)
      ) u_skew (
         .clk  (clk),
         .reset(reset),
         .d_i  (skew_in[r*DATA_SIZE +: DATA_SIZE]),
         .q_o  (row_data[r*DATA_SIZE +: DATA_SIZE])
      );
   end

   assign col_sum   = col_sum_q;
   assign ld_weight = ld_weight_q;
   assign enable    = enable_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder against a timestamp-based reference model.
// Expected outputs are scheduled per absolute cycle from the protocol rules.
module tb_systolic_feeder;

   localparam int DS        = 32;
   localparam int N         = 4;
   localparam int SKEW      = 4;
   localparam int W         = N * DS;
   localparam int DRAIN_LEN = (N - 1) * SKEW + N * SKEW;
   localparam int MAXC      = 6000;

   localparam int M_IDLE   = 0;
   localparam int M_FILL   = 1;
   localparam int M_BURST  = 2;
   localparam int M_STREAM = 3;
   localparam int M_DRAIN  = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid, in_weight, in_last;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [W-1:0] row_data, col_sum;
   logic         ld_weight, enable, busy, err;

   systolic_feeder #(
      .DATA_SIZE(DS), .N(N), .SKEW(SKEW), .DRAIN_EXTRA(N * SKEW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_weight(in_weight),
      .in_last  (in_last),
      .row_data (row_data),
      .col_sum  (col_sum),
      .ld_weight(ld_weight),
      .enable   (enable),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [W-1:0] exp_row [MAXC];
   logic [W-1:0] exp_col [MAXC];
   logic [W-1:0] wb [N];
   int           mode, nfill, burst_end, drain_end;
   logic         err_m;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic schedule_vec(input logic [W-1:0] d);
      for (int r = 0; r < N; r++) begin
         exp_row[cyc + 1 + r * SKEW][r*DS +: DS] = d[r*DS +: DS];
      end
   endtask

   task automatic start_burst();
      for (int j = 0; j < N; j++) begin
         exp_col[cyc + 1 + j] = wb[N - 1 - j];
      end
      burst_end = cyc + N;
      mode      = M_BURST;
   endtask

   // One clock cycle: check outputs of this cycle, drive inputs, advance the model.
   task automatic step(input logic v, input logic w, input logic l,
                       input logic [W-1:0] d, input logic rst);
      logic rdy, acc;
      chk("row_data", row_data, exp_row[cyc]);
      chk("col_sum", col_sum, exp_col[cyc]);
      chk("ld_weight", W'(ld_weight), W'(mode == M_BURST));
      chk("enable", W'(enable),
          W'(mode == M_BURST || mode == M_STREAM || mode == M_DRAIN));
      chk("busy", W'(busy), W'(mode != M_IDLE));
      chk("err", W'(err), W'(err_m));
      reset     = rst;
      in_valid  = v;
      in_weight = w;
      in_last   = l;
      in_data   = d;
      #1;
      rdy = !rst && (mode == M_IDLE || mode == M_FILL || mode == M_STREAM);
      chk("in_ready", W'(in_ready), W'(rdy));
      acc = v && rdy;
      if (rst) begin
         mode  = M_IDLE;
         err_m = 1'b0;
         nfill = 0;
         for (int k = cyc + 1; k < cyc + 40 && k < MAXC; k++) begin
            exp_row[k] = '0;
            exp_col[k] = '0;
         end
      end else begin
         case (mode)
            M_IDLE: if (acc) begin
               if (w) begin
                  wb[0] = d;
                  nfill = 1;
                  if (nfill == N) start_burst();
                  else mode = M_FILL;
               end else begin
                  schedule_vec(d);
                  if (l) begin
                     mode      = M_DRAIN;
                     drain_end = cyc + DRAIN_LEN;
                  end else begin
                     mode = M_STREAM;
                  end
               end
            end
            M_FILL: if (acc) begin
               if (!w) err_m = 1'b1;
               wb[nfill] = d;
               nfill++;
               if (nfill == N) start_burst();
            end
            M_BURST: if (cyc + 1 > burst_end) mode = M_IDLE;
            M_STREAM: if (acc) begin
               if (w) err_m = 1'b1;
               schedule_vec(d);
               if (l) begin
                  mode      = M_DRAIN;
                  drain_end = cyc + DRAIN_LEN;
               end
            end
            M_DRAIN: if (cyc + 1 > drain_end) mode = M_IDLE;
            default: mode = M_IDLE;
         endcase
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [W-1:0] splat(input logic [DS-1:0] x);
      return {N{x}};
   endfunction

   initial begin
      logic [W-1:0] vec;
      logic         v, w, l, rst;
      int           en_cnt;

      for (int k = 0; k < MAXC; k++) begin
         exp_row[k] = '0;
         exp_col[k] = '0;
      end
      mode      = M_IDLE;
      nfill     = 0;
      burst_end = 0;
      drain_end = 0;
      err_m     = 1'b0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_weight = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      repeat (2) @(posedge clk);
      #1;

      // weight load 0x10..0x40, then idle through the burst
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 1; i <= N; i++) step(1'b1, 1'b1, 1'b0, splat(DS'(16 * i)), 1'b0);
      for (int i = 0; i < N + 2; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);

      // single vector [1,2,3,4] with in_last; count enable-high cycles
      vec = {32'd4, 32'd3, 32'd2, 32'd1};
      step(1'b1, 1'b0, 1'b1, vec, 1'b0);
      en_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (enable) en_cnt++;
         step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      end
      chk("drain_cycles", W'(en_cnt), W'(DRAIN_LEN));

      // three vectors with a one-cycle gap, then a weight beat mid-stream
      step(1'b1, 1'b0, 1'b0, {32'd13, 32'd12, 32'd11, 32'd10}, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, {32'd23, 32'd22, 32'd21, 32'd20}, 1'b0);
      step(1'b1, 1'b1, 1'b0, splat(32'hdead), 1'b0);
      step(1'b1, 1'b0, 1'b1, {32'd33, 32'd32, 32'd31, 32'd30}, 1'b0);
      for (int k = 0; k < DRAIN_LEN + 4; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      chk("err_sticky", W'(err), W'(1));

      // reset in the second cycle of a weight burst
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      for (int i = 1; i <= N; i++) step(1'b1, 1'b1, 1'b0, splat(DS'(i)), 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk("abort_ld", W'(ld_weight), W'(0));
      chk("abort_col", col_sum, '0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);

      // randomized traffic
      for (int k = 0; k < 2500; k++) begin
         v   = ($urandom % 4) != 0;
         rst = ($urandom % 400) == 0;
         case (mode)
            M_FILL:   w = ($urandom % 10) != 0;
            M_STREAM: w = ($urandom % 20) == 0;
            default:  w = 1'($urandom % 2);
         endcase
         l   = (mode == M_STREAM) ? (($urandom % 8) == 0) : (($urandom % 3) == 0);
         vec = {$urandom, $urandom, $urandom, $urandom};
         step(v, w, l, vec, rst);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
